// File: rtl/cla_add_sequencer_pkg.sv
// Shared types and sizing helpers for the digit-serial CLA adder sequencer.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    function automatic int ndigits(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/cla_add_sequencer_add4.sv
// 4-bit carry-lookahead adder slice; the only adder in the sequencer datapath.
module CLA_Add4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cIn,
    output logic [3:0] s,
    output logic       cOut
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [3:0] c_s;

    assign g_s = x & y;
    assign p_s = x ^ y;

    // All digit carries come straight from generate/propagate terms, with no ripple.
    assign c_s[0] = cIn;
    assign c_s[1] = g_s[0] | (p_s[0] & cIn);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cIn);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cIn);
    assign cOut   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cIn);

    assign s = p_s ^ c_s;

endmodule

// File: rtl/cla_add_sequencer.sv
// Multi-cycle WIDTH-bit adder: one CLA_Add4 slice reused LSB digit first, carry held in a register.
// Optional subtraction (sub port, a-b) is enabled by defining CLA_SUB_EN.
module cla_add_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NDIG  = ndigits(WIDTH);
    localparam int CNT_W = $clog2(NDIG);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIG - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               cin0_r;
    logic [WIDTH-1:0]   sum_r;
    logic               c_out_r;
    logic               ovf_r;
    logic               out_valid_r;
    logic               in_ready_r;
    logic               busy_r;

    logic [WIDTH-1:0]   be_s;
    logic               cin0_s;
    logic [DIGIT_W-1:0] x_s;
    logic [DIGIT_W-1:0] y_s;
    logic               c_slice_s;
    logic [DIGIT_W-1:0] s_s;
    logic               c_digit_s;

`ifdef CLA_SUB_EN
    // Effective b and digit-0 carry: subtraction is a + ~b + 1, so c_in is ignored.
    always_comb begin
        be_s   = b;
        cin0_s = c_in;
        if (sub) begin
            be_s   = ~b;
            cin0_s = 1'b1;
        end else begin
            be_s   = b;
            cin0_s = c_in;
        end
    end
`else
    // Effective b and digit-0 carry for the add-only build.
    always_comb begin
        be_s   = b;
        cin0_s = c_in;
    end
`endif

    // Select the current digit and its carry-in for the shared slice.
    always_comb begin
        x_s       = a_r[int'(cnt_r) * DIGIT_W +: DIGIT_W];
        y_s       = b_r[int'(cnt_r) * DIGIT_W +: DIGIT_W];
        c_slice_s = carry_r;
        if (cnt_r == CNT_ZERO) begin
            c_slice_s = cin0_r;
        end else begin
            c_slice_s = carry_r;
        end
    end

    CLA_Add4 u_add4 (
        .x    (x_s),
        .y    (y_s),
        .cIn  (c_slice_s),
        .s    (s_s),
        .cOut (c_digit_s)
    );

    // Sequencer FSM: accept operands, run one digit per cycle, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            carry_r     <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            cin0_r      <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            c_out_r     <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= be_s;
                        cin0_r     <= cin0_s;
                        cnt_r      <= CNT_ZERO;
                        carry_r    <= 1'b0;
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_r[int'(cnt_r) * DIGIT_W +: DIGIT_W] <= s_s;
                    carry_r <= c_digit_s;
                    if (cnt_r == LAST_DIGIT) begin
                        // Overflow: like-signed operands giving a result of the other sign.
                        c_out_r     <= c_digit_s;
                        ovf_r       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                       (s_s[DIGIT_W-1] != a_r[WIDTH-1]);
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign c_out     = c_out_r;
    assign ovf       = ovf_r;
    assign busy      = busy_r;

endmodule
